axi_master: RTL

AXI_MASTER -- requirements
Module: axi_master

---
 rtl/axi_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_master.sv
// Single-outstanding AXI master: turns one command into an AW/W/B or AR/R
// sequence, with a per-channel wait timeout, and returns a single response.
module axi_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  input  logic [1:0]            rresp,
  output logic                  rready
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        expired;

  // wait_cnt counts cycles already spent without a handshake, so the last
  // cycle a channel may stay open is the one where it equals TIMEOUT-1.
  assign expired = (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              awvalid <= 1'b1;
              state   <= AW;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        AW: begin
          if (awready) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b1;
            wait_cnt <= '0;
            state    <= W;
          end else if (expired) begin
            awvalid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        W: begin
          if (wready) begin
            wvalid   <= 1'b0;
            bready   <= 1'b1;
            wait_cnt <= '0;
            state    <= B;
          end else if (expired) begin
            wvalid    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= bresp;
            rsp_rdata <= '0;
            state     <= RSP;
          end else if (expired) begin
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        AR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            wait_cnt <= '0;
            state    <= R;
          end else if (expired) begin
            arvalid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= rresp;
            rsp_rdata <= rdata;
            state     <= RSP;
          end else if (expired) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_rdata <= '0;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
